// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 8 data bits, optional parity, driven by an external baud counter
module uart_rx (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rxd,
   input  logic [15:0] period,
   input  logic        tick,
   input  logic        parity_en,
   input  logic        parity_odd,
   output logic        cnt_en,
   output logic [15:0] cnt_preset,
   output logic [7:0]  data,
   output logic        valid,
   output logic        parity_err,
   output logic        frame_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t      state;
   logic        rxd_m;
   logic        rxd_s;
   logic [7:0]  shift;
   logic [2:0]  bit_idx;
   logic        par_en_l;
   logic        par_odd_l;
   logic        pend_err;

   // Half a bit period so the first tick lands mid start bit
   assign cnt_preset = period >> 1;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rxd_m <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         rxd_m <= rxd;
         rxd_s <= rxd_m;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         shift      <= 8'h00;
         bit_idx    <= 3'd0;
         par_en_l   <= 1'b0;
         par_odd_l  <= 1'b0;
         pend_err   <= 1'b0;
         data       <= 8'h00;
         valid      <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         cnt_en     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  state     <= START;
                  par_en_l  <= parity_en;
                  par_odd_l <= parity_odd;
                  pend_err  <= 1'b0;
                  cnt_en    <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (!rxd_s) begin
                     state   <= DATA;
                     bit_idx <= 3'd0;
                  end else begin
                     // Glitch shorter than half a bit: treat as a false start
                     state  <= IDLE;
                     cnt_en <= 1'b0;
                     busy   <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shift   <= {rxd_s, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= par_en_l ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (tick) begin
                  pend_err <= ^shift ^ rxd_s ^ par_odd_l;
                  state    <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  data       <= shift;
                  valid      <= 1'b1;
                  parity_err <= pend_err;
                  frame_err  <= ~rxd_s;
                  cnt_en     <= 1'b0;
                  if (rxd_s) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= WAIT_HIGH;
                  end
               end
            end
            WAIT_HIGH: begin
               // A held-low line (break) must not be read as further start bits
               if (rxd_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               cnt_en <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed-vector bench for uart_rx paired with a baud counter model
module tb_uart_rx;

   localparam int BIT_CLKS = 16;

   logic        clk = 1'b0;
   logic        rstn;
   logic        rxd;
   logic [15:0] period;
   logic        tick;
   logic        parity_en;
   logic        parity_odd;
   logic        cnt_en;
   logic [15:0] cnt_preset;
   logic [7:0]  data;
   logic        valid;
   logic        parity_err;
   logic        frame_err;
   logic        busy;

   logic [15:0] baud_cnt;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] got_q[$];

   typedef struct {
      logic [7:0] d;
      logic       pen;
      logic       podd;
      logic       pbit;
      logic       stopb;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   uart_rx dut (
      .clk        (clk),
      .rstn       (rstn),
      .rxd        (rxd),
      .period     (period),
      .tick       (tick),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .cnt_en     (cnt_en),
      .cnt_preset (cnt_preset),
      .data       (data),
      .valid      (valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   // Baud counter: holds preset while disabled, wraps at period-1
   always_ff @(posedge clk) begin
      if (!rstn || !cnt_en)
         baud_cnt <= cnt_preset;
      else if (baud_cnt == period - 16'd1)
         baud_cnt <= 16'd0;
      else
         baud_cnt <= baud_cnt + 16'd1;
   end
   assign tick = (baud_cnt == period - 16'd1);

   always @(negedge clk) begin
      if (valid)
         got_q.push_back(data);
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (BIT_CLKS) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stopb);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++)
         send_bit(d[i]);
      if (pen)
         send_bit(pbit);
      send_bit(stopb);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(posedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " data"}, {8'h00, data}, 16'h0000);
      chk({tag, " valid"}, {15'd0, valid}, 16'd0);
      chk({tag, " parity_err"}, {15'd0, parity_err}, 16'd0);
      chk({tag, " frame_err"}, {15'd0, frame_err}, 16'd0);
      chk({tag, " cnt_en"}, {15'd0, cnt_en}, 16'd0);
      chk({tag, " busy"}, {15'd0, busy}, 16'd0);
   endtask

   initial begin
      int n0;

      vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hA3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      rstn       = 1'b0;
      rxd        = 1'b1;
      period     = 16'd16;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      chk("cnt_preset", cnt_preset, 16'd8);
      @(posedge clk);
      rstn = 1'b1;
      idle(4);

      foreach (vecs[k]) begin
         parity_en  = vecs[k].pen;
         parity_odd = vecs[k].podd;
         n0 = got_q.size();
         send_frame(vecs[k].d, vecs[k].pen, vecs[k].pbit, vecs[k].stopb);
         idle(20);
         @(negedge clk);
         chk($sformatf("v%0d valid count", k), 16'(got_q.size() - n0), 16'd1);
         if (got_q.size() > n0)
            chk($sformatf("v%0d pulse data", k), {8'h00, got_q[$]}, {8'h00, vecs[k].d});
         chk($sformatf("v%0d data", k), {8'h00, data}, {8'h00, vecs[k].d});
         chk($sformatf("v%0d parity_err", k), {15'd0, parity_err}, {15'd0, vecs[k].exp_perr});
         chk($sformatf("v%0d frame_err", k), {15'd0, frame_err}, {15'd0, vecs[k].exp_ferr});
         chk($sformatf("v%0d busy", k), {15'd0, busy}, 16'd0);
         chk($sformatf("v%0d cnt_en", k), {15'd0, cnt_en}, 16'd0);
      end
      parity_en  = 1'b0;
      parity_odd = 1'b0;

      // Stop bit low, line held low: break sits in WAIT_HIGH
      n0 = got_q.size();
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      rxd = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("break valid count", 16'(got_q.size() - n0), 16'd1);
      chk("break data", {8'h00, data}, 16'h003C);
      chk("break frame_err", {15'd0, frame_err}, 16'd1);
      chk("break busy", {15'd0, busy}, 16'd1);
      chk("break cnt_en", {15'd0, cnt_en}, 16'd0);
      idle(20);
      @(negedge clk);
      chk("break release busy", {15'd0, busy}, 16'd0);
      n0 = got_q.size();
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      idle(20);
      @(negedge clk);
      chk("after break valid count", 16'(got_q.size() - n0), 16'd1);
      chk("after break data", {8'h00, data}, 16'h0081);
      chk("after break frame_err", {15'd0, frame_err}, 16'd0);

      // Short low glitch: false start
      n0 = got_q.size();
      rxd = 1'b0;
      repeat (3) @(posedge clk);
      rxd = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("glitch busy in START", {15'd0, busy}, 16'd1);
      chk("glitch cnt_en in START", {15'd0, cnt_en}, 16'd1);
      idle(30);
      @(negedge clk);
      chk("glitch valid count", 16'(got_q.size() - n0), 16'd0);
      chk("glitch busy", {15'd0, busy}, 16'd0);
      chk("glitch cnt_en", {15'd0, cnt_en}, 16'd0);
      chk("glitch data held", {8'h00, data}, 16'h0081);

      // Reset during the 4th data bit
      n0 = got_q.size();
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rxd = 1'b0;
      repeat (8) @(posedge clk);
      rxd  = 1'b1;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("midframe reset");
      @(posedge clk);
      rstn = 1'b1;
      idle(200);
      @(negedge clk);
      chk("midframe reset valid count", 16'(got_q.size() - n0), 16'd0);
      chk("midframe reset busy", {15'd0, busy}, 16'd0);
      n0 = got_q.size();
      send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
      idle(20);
      @(negedge clk);
      chk("post reset valid count", 16'(got_q.size() - n0), 16'd1);
      chk("post reset data", {8'h00, data}, 16'h00F0);

      // Back-to-back frames, no idle gap
      n0 = got_q.size();
      send_frame(8'h12, 1'b0, 1'b0, 1'b1);
      send_frame(8'h34, 1'b0, 1'b0, 1'b1);
      idle(20);
      @(negedge clk);
      chk("b2b valid count", 16'(got_q.size() - n0), 16'd2);
      if (got_q.size() >= n0 + 2) begin
         chk("b2b first data", {8'h00, got_q[n0]}, 16'h0012);
         chk("b2b second data", {8'h00, got_q[n0 + 1]}, 16'h0034);
      end
      chk("b2b parity_err", {15'd0, parity_err}, 16'd0);
      chk("b2b frame_err", {15'd0, frame_err}, 16'd0);
      chk("b2b busy", {15'd0, busy}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
